// File: rtl/multiword_add_sequencer_if.sv
// Operand/result handshake bundle for multiword_add_sequencer.
// The master drives operands and out_ready. The slave is the sequencer itself.
interface multiword_add_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Adds or subtracts WIDTH-bit operands through one shared SLICE-bit adder.
// It processes one slice per clock, LSB first, and keeps the inter-slice carry in a register.
module multiword_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multiword_add_sequencer_if.slave bus
);
  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IDX_W-1:0] r_idx;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE:0]   w_res;
  logic             w_msb_cin;
  logic             w_last;
  logic             w_accept;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;

  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int unsigned k = 0; k < NUM_SLICES; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_sl = r_a[k*SLICE +: SLICE];
        w_b_sl = r_b[k*SLICE +: SLICE];
      end
    end
  end

  assign w_res = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
  // The carry into the slice MSB is recovered from the sum bit. This avoids a second adder.
  assign w_msb_cin = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_res[SLICE-1];
  assign w_last    = (r_idx == IDX_W'(NUM_SLICES - 1));

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.in_a;
      r_b     <= bus.in_sub ? ~bus.in_b : bus.in_b;
      r_carry <= bus.in_sub ? 1'b1 : bus.in_cin;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      for (int unsigned k = 0; k < NUM_SLICES; k++) begin
        if (r_idx == IDX_W'(k)) r_sum[k*SLICE +: SLICE] <= w_res[SLICE-1:0];
      end
      r_carry <= w_res[SLICE];
      r_idx   <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_cout <= w_res[SLICE];
        r_ovf  <= w_msb_cin ^ w_res[SLICE];
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;
  assign bus.out_ovf   = r_ovf;
endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Multi-cycle controller that time-shares one SLICE-bit ripple-carry adder slice to add or subtract WIDTH-bit operands, one slice per clock, LSB slice first.
- The carry between slices is held in a register.
- Operands enter and results leave through valid/ready handshakes.
- Sits between operand producers and result consumers wherever a full-width adder is too costly in area.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of SLICE.
- SLICE, 8, bits added per cycle (width of the shared adder slice); 1 <= SLICE <= WIDTH.
- NUM_SLICES is derived as WIDTH/SLICE; it is not a port-level parameter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_sub  input  1  1 = A-B, 0 = A+B+in_cin
- in_cin  input  1  carry-in for add; ignored when in_sub=1
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- out_ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, any state): state=IDLE; in_ready=1; out_valid=0; busy=0; out_sum, out_cout, out_ovf, carry register, slice index and operand registers all 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_a and (in_sub ? ~in_b : in_b).
  - Set carry = in_sub ? 1 : in_cin, slice index=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, compute slice k = A[k*SLICE +: SLICE] + Bop[k*SLICE +: SLICE] + carry.
  - Write the slice to out_sum[k*SLICE +: SLICE], update carry, k++.
  - On slice k=NUM_SLICES-1:
    - capture out_cout = slice carry-out;
    - capture out_ovf = carry into bit WIDTH-1 XOR out_cout;
    - go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum, out_cout and out_ovf are held stable until out_valid&&out_ready.
  - On that handshake, go to IDLE and drop out_valid next cycle.
- Latency: with acceptance at edge E0, out_valid rises after edge E(NUM_SLICES), i.e. NUM_SLICES cycles later. NUM_SLICES=1 gives a single RUN cycle.
- Throughput: one operation per NUM_SLICES+2 cycles minimum.
  - There is no overlap: in_ready stays 0 until IDLE is re-entered.
  - An in_valid held through DONE is accepted in the first IDLE cycle.
- Boundary conditions:
  - Inputs are sampled only at acceptance. Changes to in_a, in_b, in_sub or in_cin during RUN/DONE have no effect.
  - out_ready while not in DONE is ignored.
  - Arithmetic is modulo 2^WIDTH. out_sum upper slices may show stale/partial values during RUN; only DONE values are defined.
  - Reset asserted mid-RUN or mid-DONE aborts the operation: all outputs go to reset values immediately (asynchronous), and no result is emitted.
  - After reset release, the block is in IDLE with in_ready=1 on the first clock.

Test Plan (WIDTH=32, SLICE=8):
- Add 0x00FF_FFFF + 0x0000_0001, cin=0 -> out_sum=0x0100_0000, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- Add 0xFFFF_FFFF + 0x0000_0000, cin=1 -> out_sum=0x0000_0000, cout=1, ovf=0. Add 0x7FFF_FFFF + 0x0000_0001 -> out_sum=0x8000_0000, cout=0, ovf=1.
- Subtract 5 - 7 with in_cin=1 (must be ignored) -> out_sum=0xFFFF_FFFE, cout=0, ovf=0. Subtract 0x8000_0000 - 1 -> out_sum=0x7FFF_FFFF, cout=1, ovf=1.
- Backpressure: out_ready=0 for 3 cycles in DONE with a second operand held on in_valid -> outputs stable, in_ready=0. Second operand accepted the first cycle after the result handshake; both results correct and in order.
- Input mutation: change in_a/in_b/in_sub every cycle during RUN -> result equals the values present at acceptance.
- Reset: assert rst_n=0 during RUN slice 2 -> out_valid=0, out_sum=0, busy=0 with no clock edge. After release, in_ready=1 and a fresh 0x1+0x1 returns 0x2.
